// File: rtl/az_sample_ctl.sv
`timescale 1ns/1ps
// Auto-zero sequencer: alternates the input mux between signal (HI) and zero (LO),
// settles, runs one ADC measurement per phase and tags each completed sample.
module az_sample_ctl #(
   parameter logic [3:0] AZMUX_HI   = 4'b0001,
   parameter logic [3:0] AZMUX_LO   = 4'b0010,
   parameter logic [3:0] AZMUX_IDLE = 4'b0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [31:0] clk_settle_duration,
   input  logic        adc_measure_done,
   output logic        adc_measure_start,
   output logic [3:0]  azmux,
   output logic        sw_pc,
   output logic        sample_valid,
   output logic        sample_is_hi,
   output logic [15:0] sample_count,
   output logic [3:0]  monitor
);

   localparam int unsigned CNT_W = 32;
   localparam int unsigned SMP_W = 16;
   localparam int unsigned MUX_W = 4;
   localparam int unsigned MON_W = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_SWITCH, S_SETTLE, S_START, S_WAIT_LO, S_WAIT_HI, S_EMIT
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_settle_cnt, w_settle_nxt;
   logic               r_start_cnt, w_start_cnt_nxt;
   logic               r_phase_hi, w_phase_nxt;
   logic               r_start, w_start_nxt;
   logic [MUX_W-1:0]   r_azmux, w_azmux_nxt;
   logic               r_sw_pc, w_sw_pc_nxt;
   logic               r_valid, w_valid_nxt;
   logic               r_is_hi, w_is_hi_nxt;
   logic [SMP_W-1:0]   r_sample_count, w_count_nxt;
   logic [MON_W-1:0]   r_monitor, w_monitor_nxt;

   // State and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_settle_cnt   <= '0;
         r_start_cnt    <= 1'b0;
         r_phase_hi     <= 1'b1;
         r_start        <= 1'b0;
         r_azmux        <= AZMUX_IDLE;
         r_sw_pc        <= 1'b0;
         r_valid        <= 1'b0;
         r_is_hi        <= 1'b0;
         r_sample_count <= '0;
         r_monitor      <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_settle_cnt   <= w_settle_nxt;
         r_start_cnt    <= w_start_cnt_nxt;
         r_phase_hi     <= w_phase_nxt;
         r_start        <= w_start_nxt;
         r_azmux        <= w_azmux_nxt;
         r_sw_pc        <= w_sw_pc_nxt;
         r_valid        <= w_valid_nxt;
         r_is_hi        <= w_is_hi_nxt;
         r_sample_count <= w_count_nxt;
         r_monitor      <= w_monitor_nxt;
      end
   end

   // Next state, plus output values keyed on the state about to be entered
   always_comb begin
      w_state_nxt     = r_state;
      w_settle_nxt    = r_settle_cnt;
      w_start_cnt_nxt = 1'b0;
      w_phase_nxt     = r_phase_hi;
      w_azmux_nxt     = r_azmux;
      w_sw_pc_nxt     = r_sw_pc;
      w_is_hi_nxt     = r_is_hi;
      w_count_nxt     = r_sample_count;

      case (r_state)
         S_IDLE:    if (enable) w_state_nxt = S_SWITCH;
         S_SWITCH: begin
            w_settle_nxt = clk_settle_duration;
            w_state_nxt  = S_SETTLE;
         end
         S_SETTLE: begin
            if (r_settle_cnt == '0) w_state_nxt  = S_START;
            else                    w_settle_nxt = r_settle_cnt - CNT_W'(1);
         end
         S_START: begin
            if (r_start_cnt) w_state_nxt     = S_WAIT_LO;
            else             w_start_cnt_nxt = 1'b1;
         end
         S_WAIT_LO: if (!adc_measure_done) w_state_nxt = S_WAIT_HI;
         S_WAIT_HI: if (adc_measure_done)  w_state_nxt = S_EMIT;
         S_EMIT:    w_state_nxt = enable ? S_SWITCH : S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase

      // Phase flips on entering EMIT so the following SWITCH picks the other node
      case (w_state_nxt)
         S_IDLE: begin
            w_azmux_nxt = AZMUX_IDLE;
            w_sw_pc_nxt = 1'b0;
         end
         S_SWITCH: begin
            w_azmux_nxt = r_phase_hi ? AZMUX_HI : AZMUX_LO;
            w_sw_pc_nxt = r_phase_hi;
         end
         S_EMIT: begin
            w_is_hi_nxt = r_phase_hi;
            w_count_nxt = r_sample_count + SMP_W'(1);
            w_phase_nxt = ~r_phase_hi;
         end
         default: ;
      endcase

      w_start_nxt   = (w_state_nxt == S_START);
      w_valid_nxt   = (w_state_nxt == S_EMIT);
      w_monitor_nxt = {w_state_nxt == S_EMIT,
                       (w_state_nxt == S_WAIT_LO) || (w_state_nxt == S_WAIT_HI),
                       w_state_nxt == S_SETTLE,
                       w_state_nxt == S_START};
   end

   assign adc_measure_start = r_start;
   assign azmux             = r_azmux;
   assign sw_pc             = r_sw_pc;
   assign sample_valid      = r_valid;
   assign sample_is_hi      = r_is_hi;
   assign sample_count      = r_sample_count;
   assign monitor           = r_monitor;

endmodule

// File: tb/tb_az_sample_ctl.sv
`timescale 1ns/1ps
// Bench for az_sample_ctl: ADC responder, phase-timeline reference model,
// vector table, randomized runs and hand-written corner sequences.
module tb_az_sample_ctl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] clk_settle_duration = 32'd0;
   logic        adc_measure_done;
   logic        adc_measure_start;
   logic [3:0]  azmux;
   logic        sw_pc;
   logic        sample_valid;
   logic        sample_is_hi;
   logic [15:0] sample_count;
   logic [3:0]  monitor;

   int unsigned n_checks = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   az_sample_ctl dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .enable              (enable),
      .clk_settle_duration (clk_settle_duration),
      .adc_measure_done    (adc_measure_done),
      .adc_measure_start   (adc_measure_start),
      .azmux               (azmux),
      .sw_pc               (sw_pc),
      .sample_valid        (sample_valid),
      .sample_is_hi        (sample_is_hi),
      .sample_count        (sample_count),
      .monitor             (monitor)
   );

   // ADC responder: done idles high after reset, drops on start, pulses after adc_d clocks
   int unsigned adc_d = 10;
   bit          adc_hang = 1'b0;
   logic        adc_busy;
   logic        adc_pulsed;
   int unsigned adc_cnt;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         adc_measure_done <= 1'b1;
         adc_busy         <= 1'b0;
         adc_pulsed       <= 1'b0;
         adc_cnt          <= 0;
      end else if (adc_measure_start && !adc_busy) begin
         adc_busy         <= 1'b1;
         adc_cnt          <= adc_d;
         adc_measure_done <= 1'b0;
         adc_pulsed       <= 1'b0;
      end else if (adc_busy) begin
         if (adc_cnt == 1 && !adc_hang) begin
            adc_busy         <= 1'b0;
            adc_measure_done <= 1'b1;
            adc_pulsed       <= 1'b1;
         end else if (adc_cnt > 1) begin
            adc_cnt <= adc_cnt - 1;
         end
      end else if (adc_pulsed) begin
         adc_measure_done <= 1'b0;
         adc_pulsed       <= 1'b0;
      end
   end

   // Reference model: position within the current phase, measured from the mux switch
   bit          m_active;
   int unsigned m_off;
   int unsigned m_s;
   bit          m_hi;
   bit          m_last_hi;
   logic [15:0] m_count;
   logic [3:0]  prev_mux;

   function automatic logic [27:0] model_exp();
      logic st, se, wt, vl, pc;
      logic [3:0] mux;
      st = 1'b0; se = 1'b0; wt = 1'b0; vl = 1'b0; pc = 1'b0; mux = 4'b0000;
      if (m_active) begin
         mux = m_hi ? 4'b0001 : 4'b0010;
         pc  = m_hi;
         st  = (m_off == m_s + 2) || (m_off == m_s + 3);
         se  = (m_off >= 1) && (m_off <= m_s + 1);
         wt  = (m_off >= m_s + 4) && (m_off <= m_s + adc_d + 3);
         vl  = (m_off == m_s + adc_d + 4);
      end
      return {st, mux, pc, vl, m_last_hi, m_count, vl, wt, se, st};
   endfunction

   task automatic model_reset();
      m_active = 1'b0; m_off = 0; m_s = 0; m_hi = 1'b1; m_last_hi = 1'b0; m_count = 16'd0;
      prev_mux = 4'b0000;
   endtask

   // Advance the model across the coming rising edge using the inputs now applied
   task automatic model_advance();
      if (!m_active) begin
         if (enable) begin m_active = 1'b1; m_off = 0; end
      end else if (m_off == 0) begin
         m_s = clk_settle_duration; m_off = 1;
      end else if (m_off == m_s + adc_d + 4) begin
         m_hi = !m_hi;
         if (enable) m_off = 0;
         else        m_active = 1'b0;
      end else begin
         m_off = m_off + 1;
         if (m_off == m_s + adc_d + 4) begin
            m_last_hi = m_hi;
            m_count   = m_count + 16'd1;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   function automatic logic [27:0] dut_vec();
      return {adc_measure_start, azmux, sw_pc, sample_valid, sample_is_hi, sample_count, monitor};
   endfunction

   task automatic sample_and_check();
      @(negedge clk);
      check("cycle_outputs", 32'(dut_vec()), 32'(model_exp()));
      if (azmux !== prev_mux) check("start_on_mux_change", 32'(adc_measure_start), 32'd0);
      prev_mux = azmux;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      enable  = 1'b0;
      #1 check("reset_values", 32'(dut_vec()), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      model_advance();
   endtask

   typedef struct {
      int unsigned s;
      int unsigned d;
      int unsigned n;
      int          lat;
      logic [15:0] cnt;
      logic        last_hi;
   } vec_t;

   vec_t tv [4];

   initial begin
      tv[0] = '{3, 10, 2, 17, 16'd2, 1'b0};
      tv[1] = '{0, 2,  2, 6,  16'd2, 1'b0};
      tv[2] = '{0, 5,  3, 9,  16'd3, 1'b1};
      tv[3] = '{7, 3,  1, 14, 16'd1, 1'b1};
      model_reset();

      // Vector table: S, D, sample count, switch-to-valid latency, final tag
      for (int i = 0; i < 4; i++) begin
         int unsigned n, st_cyc, se_cyc;
         int sw, lat;
         adc_d = tv[i].d;
         clk_settle_duration = tv[i].s;
         do_reset();
         n = 0; st_cyc = 0; se_cyc = 0; sw = -1; lat = -1;
         for (int c = 0; c < 300; c++) begin
            sample_and_check();
            if (sw < 0 && azmux != 4'b0000) sw = c;
            if (adc_measure_start) st_cyc++;
            if (monitor[1]) se_cyc++;
            if (sample_valid) begin
               n++;
               if (n == 1) lat = c - sw;
            end
            enable = (n < tv[i].n);
            model_advance();
         end
         check("vec_latency", 32'(lat), 32'(tv[i].lat));
         check("vec_samples", n, tv[i].n);
         check("vec_start_clks", st_cyc, 2 * tv[i].n);
         check("vec_settle_clks", se_cyc, tv[i].n * (tv[i].s + 1));
         check("vec_count", 32'(sample_count), 32'(tv[i].cnt));
         check("vec_last_hi", 32'(sample_is_hi), 32'(tv[i].last_hi));
         check("vec_idle_mux", 32'(azmux), 32'd0);
      end

      // Randomized runs: random S/D, enable dropouts and mid-phase settle changes
      for (int r = 0; r < 4; r++) begin
         adc_d = $urandom_range(2, 12);
         clk_settle_duration = $urandom_range(0, 6);
         do_reset();
         for (int c = 0; c < 700; c++) begin
            sample_and_check();
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) clk_settle_duration = $urandom_range(0, 6);
            model_advance();
         end
      end

      // Enable dropped while the LO phase settles: LO sample completes, then resume on HI
      begin
         bit hit;
         adc_d = 4; clk_settle_duration = 32'd4;
         do_reset();
         hit = 1'b0;
         for (int c = 0; c < 100 && !hit; c++) begin
            sample_and_check(); hit = sample_valid; enable = 1'b1; model_advance();
         end
         check("drop_first_valid", 32'(hit), 32'd1);
         hit = 1'b0;
         for (int c = 0; c < 20 && !hit; c++) begin
            sample_and_check(); hit = monitor[1]; enable = !hit; model_advance();
         end
         check("drop_lo_settle", 32'({hit, azmux, sw_pc}), 32'({1'b1, 4'b0010, 1'b0}));
         hit = 1'b0;
         for (int c = 0; c < 100 && !hit; c++) begin
            sample_and_check(); hit = sample_valid; enable = 1'b0; model_advance();
         end
         check("drop_lo_sample", 32'({hit, sample_is_hi, sample_count}), 32'({1'b1, 1'b0, 16'd2}));
         for (int c = 0; c < 10; c++) begin
            sample_and_check(); enable = 1'b0; model_advance();
         end
         check("drop_idle", 32'({azmux, monitor}), 32'd0);
         sample_and_check(); enable = 1'b1; model_advance();
         sample_and_check();
         check("drop_resume_hi", 32'({azmux, sw_pc}), 32'({4'b0001, 1'b1}));
         model_advance();
      end

      // Asynchronous reset while waiting on the ADC
      begin
         bit hit;
         int unsigned bad;
         adc_d = 10; clk_settle_duration = 32'd2;
         do_reset();
         hit = 1'b0;
         for (int c = 0; c < 50 && !hit; c++) begin
            sample_and_check(); hit = monitor[2]; enable = 1'b1; model_advance();
         end
         for (int c = 0; c < 3; c++) begin
            sample_and_check(); enable = 1'b1; model_advance();
         end
         check("rst_in_wait", 32'({hit, monitor}), 32'({1'b1, 4'b0100}));
         #2 reset_n = 1'b0;
         #1 check("rst_async_values", 32'(dut_vec()), 32'd0);
         bad = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sample_valid !== 1'b0 || sample_count !== 16'd0) bad++;
         end
         check("rst_hold_quiet", bad, 0);
         do_reset();
      end

      // ADC that never finishes: parked in the wait with the mux frozen
      begin
         bit hit;
         int unsigned bad;
         logic [3:0] mux0;
         adc_hang = 1'b1; adc_d = 5; clk_settle_duration = 32'd1;
         do_reset();
         enable = 1'b1;
         hit = 1'b0;
         for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk); hit = monitor[2];
         end
         check("hang_reach_wait", 32'(hit), 32'd1);
         mux0 = azmux;
         bad = 0;
         for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (monitor[2] !== 1'b1 || sample_valid !== 1'b0 || azmux !== mux0) bad++;
         end
         check("hang_hold", bad, 0);
         check("hang_mux", 32'(mux0), 32'h1);
         adc_hang = 1'b0;
         do_reset();
      end

      // Sample counter wrap from 16'hFFFF
      begin
         bit hit;
         adc_d = 3; clk_settle_duration = 32'd1;
         do_reset();
         hit = 1'b0;
         for (int c = 0; c < 20 && !hit; c++) begin
            sample_and_check();
            hit = monitor[1];
            if (hit) begin
               force dut.r_sample_count = 16'hFFFF;
               #1 release dut.r_sample_count;
               m_count = 16'hFFFF;
            end
            enable = 1'b1;
            model_advance();
         end
         hit = 1'b0;
         for (int c = 0; c < 50 && !hit; c++) begin
            sample_and_check(); hit = sample_valid; enable = 1'b1; model_advance();
         end
         check("wrap_count", 32'({hit, sample_count}), 32'({1'b1, 16'd0}));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
